// File: rtl/mem_unit_pkg.sv
// Shared definitions for the unified instruction/data memory unit:
// FSM state encoding and default geometry / MMIO location.
package lib_mem;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } MEM_STATE;

    localparam int unsigned DEFAULT_DEPTH_WORDS = 64;
    localparam logic [31:0] DEFAULT_MMIO_ADDR   = 32'h0000_FFFC;

endpackage

// File: rtl/mem_unit_mem_array.sv
// Single-port synchronous RAM, DEPTH_WORDS x 32, registered read.
// The read register only updates on read operations, so it holds across writes.
module mem_array #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned AW          = 6
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/mem_unit.sv
// Memory unit: request FSM with fixed LATENCY, address range check,
// memory-mapped output register and read-data mux in front of mem_array.
module mem_unit
    import lib_mem::*;
#(
    parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter int unsigned LATENCY     = 2,
    parameter logic [31:0] MMIO_ADDR   = DEFAULT_MMIO_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        addr_err,
    output logic [31:0] mmio_out
);

    localparam int unsigned AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  WAIT_LAST = 4'((LATENCY >= 2) ? LATENCY - 2 : 0);

    MEM_STATE    state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic        enter_resp;

    logic [31:0] addr_q, wdata_q;
    logic        we_q;
    logic [31:0] acc_addr, acc_wdata;
    logic        acc_we;

    logic        is_mmio, is_err, commit, ram_en;
    logic [31:0] ram_rdata, rdata_q, mmio_q;
    logic        rdata_from_ram, err_q;

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        enter_resp = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    cnt_nx = '0;
                    if (LATENCY == 1) begin
                        state_nx   = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_nx = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == WAIT_LAST) begin
                    state_nx   = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_nx = cnt + 4'd1;
                end
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // With LATENCY=1 the access commits on its own sample edge, so use the live inputs there.
    always_comb begin
        acc_addr  = (state == IDLE) ? addr  : addr_q;
        acc_we    = (state == IDLE) ? we    : we_q;
        acc_wdata = (state == IDLE) ? wdata : wdata_q;
        is_mmio   = (acc_addr == MMIO_ADDR);
        is_err    = (acc_addr[1:0] != 2'b00) ||
                    (!is_mmio && (acc_addr[31:2] >= 30'(DEPTH_WORDS)));
        commit    = enter_resp && !reset;
        ram_en    = commit && !is_err && !is_mmio;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            rdata_q        <= '0;
            rdata_from_ram <= 1'b0;
            mmio_q         <= '0;
            err_q          <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (state == IDLE && req) begin
                addr_q  <= addr;
                we_q    <= we;
                wdata_q <= wdata;
            end
            if (commit) begin
                err_q <= is_err;
                if (!acc_we) begin
                    if (is_err) begin
                        rdata_q        <= '0;
                        rdata_from_ram <= 1'b0;
                    end else if (is_mmio) begin
                        rdata_q        <= mmio_q;
                        rdata_from_ram <= 1'b0;
                    end else begin
                        rdata_from_ram <= 1'b1;
                    end
                end else if (is_mmio && !is_err) begin
                    mmio_q <= acc_wdata;
                end
            end
        end
    end

    mem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_mem_array (
        .clk  (clk),
        .en   (ram_en),
        .we   (acc_we),
        .addr (acc_addr[AW+1:2]),
        .wdata(acc_wdata),
        .rdata(ram_rdata)
    );

    assign ready    = (state == RESP) && !reset;
    assign addr_err = ready && err_q;
    assign rdata    = rdata_from_ram ? ram_rdata : rdata_q;
    assign mmio_out = mmio_q;

endmodule
